if_fetch_unit: RTL and testbench

Instruction-fetch stage that drives the IF/ID pipeline register. It owns the PC, runs a req/ready handshake with instruction memory, and presents `IF_PC`/`IF_Instruction` each cycle. It applies redirects from later stages and drives `ID_Flush` into IF/ID. Because IF/ID has no enable, the unit replays its last output to hold ID, and emits a NOP bubble whenever no valid instruction is available.

---
 rtl/pipe_pkg.sv | 25 ++
 rtl/fetch_replay_buf.sv | 36 +++
 rtl/if_fetch_unit.sv | 131 +++++++++++++
 tb/tb_if_fetch_unit.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types and constants for the instruction-fetch stage and its IF/ID buffer.
package pipe_pkg;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_FETCH   = 2'd0,
        ST_HELD    = 2'd1,
        ST_DISCARD = 2'd2
    } fetch_st_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instruction;
    } ifid_t;

    localparam ifid_t BUBBLE = '{pc: 32'h0000_0000, instruction: NOP};

    // PC arithmetic wraps mod 2^32; low bits are carried through untouched.
    function automatic logic [31:0] pc_next(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_replay_buf.sv
// Two-entry IF/ID buffer: replay holds the last issued pair, pending holds a word
// that returned while ID was stalled.
module fetch_replay_buf
    import pipe_pkg::*;
(
    input  logic  clk,
    input  logic  reset,
    input  ifid_t fetched,
    input  logic  load_rp,
    input  logic  load_pd,
    input  logic  promote,
    input  logic  clear_pd,
    output ifid_t rp,
    output ifid_t pd
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rp <= BUBBLE;
            pd <= BUBBLE;
        end else begin
            if (promote) begin
                rp <= pd;
            end else if (load_rp) begin
                rp <= fetched;
            end
            // Promotion empties pending so a stale word can never be issued twice.
            if (clear_pd || promote) begin
                pd <= BUBBLE;
            end else if (load_pd) begin
                pd <= fetched;
            end
        end
    end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, handshakes with instruction memory and
// drives the enable-less IF/ID register with fetched words, replays or bubbles.
module if_fetch_unit
    import pipe_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        Hold,
    input  logic        Redirect,
    input  logic [31:0] Redirect_Target,
    output logic [31:0] imem_addr,
    output logic        imem_req,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic [31:0] IF_PC,
    output logic [31:0] IF_Instruction,
    output logic        ID_Flush,
    output logic [1:0]  dbg_st
);

    // Handshake: imem_req/imem_addr are held stable from the cycle imem_req rises
    // until a cycle with imem_ready=1 completes the transfer; imem_ready is
    // ignored whenever imem_req=0.

    fetch_st_t   st, st_nxt;
    logic [31:0] pc_q, pc_nxt;
    logic [31:0] tgt_q, tgt_nxt;
    logic        req;
    ifid_t       out_pair;
    ifid_t       fetched;
    ifid_t       rp, pd;
    logic        load_rp, load_pd, promote, clear_pd;

    assign fetched = '{pc: pc_next(pc_q), instruction: imem_rdata};

    fetch_replay_buf u_buf (
        .clk      (clk),
        .reset    (reset),
        .fetched  (fetched),
        .load_rp  (load_rp),
        .load_pd  (load_pd),
        .promote  (promote),
        .clear_pd (clear_pd),
        .rp       (rp),
        .pd       (pd)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st    <= ST_FETCH;
            pc_q  <= RESET_PC;
            tgt_q <= 32'h0000_0000;
        end else begin
            st    <= st_nxt;
            pc_q  <= pc_nxt;
            tgt_q <= tgt_nxt;
        end
    end

    always_comb begin
        st_nxt   = st;
        pc_nxt   = pc_q;
        tgt_nxt  = tgt_q;
        req      = 1'b0;
        out_pair = BUBBLE;
        load_rp  = 1'b0;
        load_pd  = 1'b0;
        promote  = 1'b0;
        clear_pd = 1'b0;
        case (st)
            ST_FETCH: begin
                req = 1'b1;
                if (Redirect) begin
                    // A completed fetch is simply dropped; an open one must be drained.
                    if (imem_ready) begin
                        pc_nxt = Redirect_Target;
                    end else begin
                        tgt_nxt = Redirect_Target;
                        st_nxt  = ST_DISCARD;
                    end
                end else if (imem_ready) begin
                    if (Hold) begin
                        load_pd  = 1'b1;
                        st_nxt   = ST_HELD;
                        out_pair = rp;
                    end else begin
                        out_pair = fetched;
                        load_rp  = 1'b1;
                        pc_nxt   = pc_next(pc_q);
                    end
                end else if (Hold) begin
                    out_pair = rp;
                end
            end
            ST_HELD: begin
                if (Redirect) begin
                    clear_pd = 1'b1;
                    pc_nxt   = Redirect_Target;
                    st_nxt   = ST_FETCH;
                end else if (Hold) begin
                    out_pair = rp;
                end else begin
                    out_pair = pd;
                    promote  = 1'b1;
                    pc_nxt   = pc_next(pc_q);
                    st_nxt   = ST_FETCH;
                end
            end
            ST_DISCARD: begin
                req = 1'b1;
                if (imem_ready) begin
                    pc_nxt = Redirect ? Redirect_Target : tgt_q;
                    st_nxt = ST_FETCH;
                end else if (Redirect) begin
                    tgt_nxt = Redirect_Target;
                end
            end
            default: begin
                st_nxt = ST_FETCH;
            end
        endcase
    end

    assign imem_req       = req & ~reset;
    assign imem_addr      = pc_q;
    assign IF_PC          = reset ? 32'h0000_0000 : out_pair.pc;
    assign IF_Instruction = reset ? NOP : out_pair.instruction;
    assign ID_Flush       = Redirect & ~reset;
    assign dbg_st         = st;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed self-checking bench for if_fetch_unit.
module tb_if_fetch_unit;

    logic        clk;
    logic        reset;
    logic        Hold;
    logic        Redirect;
    logic [31:0] Redirect_Target;
    logic [31:0] imem_addr;
    logic        imem_req;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic [31:0] IF_PC;
    logic [31:0] IF_Instruction;
    logic        ID_Flush;
    logic [1:0]  dbg_st;

    int n_tests;
    int n_fail;

    localparam logic [1:0] S_FETCH   = 2'd0;
    localparam logic [1:0] S_HELD    = 2'd1;
    localparam logic [1:0] S_DISCARD = 2'd2;

    if_fetch_unit dut (
        .clk             (clk),
        .reset           (reset),
        .Hold            (Hold),
        .Redirect        (Redirect),
        .Redirect_Target (Redirect_Target),
        .imem_addr       (imem_addr),
        .imem_req        (imem_req),
        .imem_rdata      (imem_rdata),
        .imem_ready      (imem_ready),
        .IF_PC           (IF_PC),
        .IF_Instruction  (IF_Instruction),
        .ID_Flush        (ID_Flush),
        .dbg_st          (dbg_st)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic apply_reset();
        reset = 1'b1; Hold = 1'b0; Redirect = 1'b0; Redirect_Target = 32'h0;
        imem_ready = 1'b0; imem_rdata = 32'h0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // One cycle of stimulus, applied after the falling edge; outputs are
    // checked 1 time unit later, well before the next rising edge.
    task automatic drive(input logic h, input logic r, input logic [31:0] t,
                         input logic rdy, input logic [31:0] d);
        @(negedge clk);
        Hold = h; Redirect = r; Redirect_Target = t; imem_ready = rdy; imem_rdata = d;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; Hold = 1'b1; Redirect = 1'b1; Redirect_Target = 32'h40;
        imem_ready = 1'b1; imem_rdata = 32'hFFFF_FFFF;
        @(negedge clk); #1;
        n_tests++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL rst_req got %b exp 0", imem_req); end
        n_tests++; if (IF_PC !== 32'h0) begin n_fail++; $display("FAIL rst_pc got %h exp 0", IF_PC); end
        n_tests++; if (IF_Instruction !== 32'h0) begin n_fail++; $display("FAIL rst_ins got %h exp 0", IF_Instruction); end
        n_tests++; if (ID_Flush !== 1'b0) begin n_fail++; $display("FAIL rst_flush got %b exp 0", ID_Flush); end
        n_tests++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL rst_addr got %h exp 0", imem_addr); end
        apply_reset();
    endtask

    task automatic test_zero_wait();
        apply_reset();
        drive(0, 0, 0, 1, 32'h2001_0001);
        n_tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin n_fail++; $display("FAIL zw_addr0 got %b/%h exp 1/0", imem_req, imem_addr); end
        n_tests++; if (IF_PC !== 32'h4 || IF_Instruction !== 32'h2001_0001) begin n_fail++; $display("FAIL zw_out0 got %h/%h exp 4/20010001", IF_PC, IF_Instruction); end
        drive(0, 0, 0, 1, 32'h2002_0002);
        n_tests++; if (imem_addr !== 32'h4) begin n_fail++; $display("FAIL zw_addr1 got %h exp 4", imem_addr); end
        n_tests++; if (IF_PC !== 32'h8 || IF_Instruction !== 32'h2002_0002) begin n_fail++; $display("FAIL zw_out1 got %h/%h exp 8/20020002", IF_PC, IF_Instruction); end
        drive(0, 0, 0, 0, 32'h0);
        n_tests++; if (imem_addr !== 32'h8 || imem_req !== 1'b1) begin n_fail++; $display("FAIL zw_addr2 got %b/%h exp 1/8", imem_req, imem_addr); end
        n_tests++; if (IF_PC !== 32'h0 || IF_Instruction !== 32'h0) begin n_fail++; $display("FAIL zw_bubble got %h/%h exp 0/0", IF_PC, IF_Instruction); end
    endtask

    task automatic test_wait_states();
        apply_reset();
        for (int i = 0; i < 2; i++) begin
            drive(0, 0, 0, 0, 32'h5555_5555);
            n_tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin n_fail++; $display("FAIL ws_hold%0d got %b/%h exp 1/0", i, imem_req, imem_addr); end
            n_tests++; if (IF_PC !== 32'h0 || IF_Instruction !== 32'h0) begin n_fail++; $display("FAIL ws_bubble%0d got %h/%h exp 0/0", i, IF_PC, IF_Instruction); end
        end
        drive(0, 0, 0, 1, 32'hAAAA_0001);
        n_tests++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL ws_addr got %h exp 0", imem_addr); end
        n_tests++; if (IF_PC !== 32'h4 || IF_Instruction !== 32'hAAAA_0001) begin n_fail++; $display("FAIL ws_out got %h/%h exp 4/aaaa0001", IF_PC, IF_Instruction); end
        drive(0, 0, 0, 0, 32'h0);
        n_tests++; if (imem_addr !== 32'h4) begin n_fail++; $display("FAIL ws_next got %h exp 4", imem_addr); end
    endtask

    task automatic test_redirect_discard();
        apply_reset();
        drive(0, 1, 32'h100, 0, 32'h0);
        n_tests++; if (ID_Flush !== 1'b1) begin n_fail++; $display("FAIL rd_flush got %b exp 1", ID_Flush); end
        n_tests++; if (IF_PC !== 32'h0 || IF_Instruction !== 32'h0) begin n_fail++; $display("FAIL rd_bubble got %h/%h exp 0/0", IF_PC, IF_Instruction); end
        drive(0, 0, 0, 0, 32'h0);
        n_tests++; if (ID_Flush !== 1'b0 || dbg_st !== S_DISCARD) begin n_fail++; $display("FAIL rd_discard got %b/%0d exp 0/2", ID_Flush, dbg_st); end
        n_tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin n_fail++; $display("FAIL rd_stable got %b/%h exp 1/0", imem_req, imem_addr); end
        drive(0, 0, 0, 1, 32'hDEAD_BEEF);
        n_tests++; if (IF_PC !== 32'h0 || IF_Instruction !== 32'h0) begin n_fail++; $display("FAIL rd_stale got %h/%h exp 0/0", IF_PC, IF_Instruction); end
        drive(0, 0, 0, 1, 32'h0000_0033);
        n_tests++; if (imem_addr !== 32'h100 || imem_req !== 1'b1) begin n_fail++; $display("FAIL rd_target got %b/%h exp 1/100", imem_req, imem_addr); end
        n_tests++; if (IF_PC !== 32'h104 || IF_Instruction !== 32'h33) begin n_fail++; $display("FAIL rd_out got %h/%h exp 104/33", IF_PC, IF_Instruction); end
    endtask

    task automatic test_hold();
        apply_reset();
        drive(0, 0, 0, 1, 32'h1111_0000);
        drive(1, 0, 0, 1, 32'h1111_0004);
        n_tests++; if (IF_PC !== 32'h4 || IF_Instruction !== 32'h1111_0000) begin n_fail++; $display("FAIL hd_rp0 got %h/%h exp 4/11110000", IF_PC, IF_Instruction); end
        for (int i = 1; i < 3; i++) begin
            drive(1, 0, 0, 1, 32'hBAD0_0000);
            n_tests++; if (IF_PC !== 32'h4 || IF_Instruction !== 32'h1111_0000) begin n_fail++; $display("FAIL hd_rp%0d got %h/%h exp 4/11110000", i, IF_PC, IF_Instruction); end
            n_tests++; if (imem_req !== 1'b0 || dbg_st !== S_HELD) begin n_fail++; $display("FAIL hd_req%0d got %b/%0d exp 0/1", i, imem_req, dbg_st); end
        end
        drive(0, 0, 0, 1, 32'hBAD0_0001);
        n_tests++; if (IF_PC !== 32'h8 || IF_Instruction !== 32'h1111_0004) begin n_fail++; $display("FAIL hd_pend got %h/%h exp 8/11110004", IF_PC, IF_Instruction); end
        drive(0, 0, 0, 1, 32'h1111_0008);
        n_tests++; if (imem_addr !== 32'h8) begin n_fail++; $display("FAIL hd_addr got %h exp 8", imem_addr); end
        n_tests++; if (IF_PC !== 32'hC || IF_Instruction !== 32'h1111_0008) begin n_fail++; $display("FAIL hd_next got %h/%h exp c/11110008", IF_PC, IF_Instruction); end
    endtask

    task automatic test_redirect_hold();
        apply_reset();
        drive(1, 1, 32'h200, 1, 32'hBAD0_0002);
        n_tests++; if (ID_Flush !== 1'b1 || IF_PC !== 32'h0 || IF_Instruction !== 32'h0) begin n_fail++; $display("FAIL rh_bubble got %b/%h/%h exp 1/0/0", ID_Flush, IF_PC, IF_Instruction); end
        drive(0, 0, 0, 1, 32'h2222_0000);
        n_tests++; if (imem_addr !== 32'h200 || dbg_st !== S_FETCH) begin n_fail++; $display("FAIL rh_target got %h/%0d exp 200/0", imem_addr, dbg_st); end
        n_tests++; if (IF_PC !== 32'h204 || IF_Instruction !== 32'h2222_0000) begin n_fail++; $display("FAIL rh_out got %h/%h exp 204/22220000", IF_PC, IF_Instruction); end
        // Redirect arriving while a word is parked in pending.
        drive(1, 0, 0, 1, 32'hBAD0_0003);
        drive(1, 1, 32'h300, 0, 32'h0);
        n_tests++; if (ID_Flush !== 1'b1 || IF_PC !== 32'h0 || IF_Instruction !== 32'h0) begin n_fail++; $display("FAIL rh_held got %b/%h/%h exp 1/0/0", ID_Flush, IF_PC, IF_Instruction); end
        drive(0, 0, 0, 1, 32'h3333_0000);
        n_tests++; if (imem_addr !== 32'h300 || imem_req !== 1'b1) begin n_fail++; $display("FAIL rh_held_addr got %b/%h exp 1/300", imem_req, imem_addr); end
        n_tests++; if (IF_PC !== 32'h304 || IF_Instruction !== 32'h3333_0000) begin n_fail++; $display("FAIL rh_held_out got %h/%h exp 304/33330000", IF_PC, IF_Instruction); end
    endtask

    task automatic test_wrap();
        apply_reset();
        drive(0, 1, 32'hFFFF_FFFC, 1, 32'hBAD0_0004);
        drive(0, 0, 0, 1, 32'h4444_0000);
        n_tests++; if (imem_addr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wr_addr got %h exp fffffffc", imem_addr); end
        n_tests++; if (IF_PC !== 32'h0 || IF_Instruction !== 32'h4444_0000) begin n_fail++; $display("FAIL wr_out got %h/%h exp 0/44440000", IF_PC, IF_Instruction); end
        drive(0, 0, 0, 0, 32'h0);
        n_tests++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL wr_next got %h exp 0", imem_addr); end
    endtask

    task automatic test_reset_mid_discard();
        apply_reset();
        drive(0, 0, 0, 1, 32'h5555_0000);
        drive(0, 1, 32'h400, 0, 32'h0);
        drive(0, 0, 0, 0, 32'h0);
        n_tests++; if (dbg_st !== S_DISCARD || imem_addr !== 32'h4) begin n_fail++; $display("FAIL rm_pre got %0d/%h exp 2/4", dbg_st, imem_addr); end
        #1;
        reset = 1'b1; Redirect = 1'b1; Redirect_Target = 32'h500;
        #1;
        n_tests++; if (imem_req !== 1'b0 || ID_Flush !== 1'b0) begin n_fail++; $display("FAIL rm_ctl got %b/%b exp 0/0", imem_req, ID_Flush); end
        n_tests++; if (IF_PC !== 32'h0 || IF_Instruction !== 32'h0) begin n_fail++; $display("FAIL rm_out got %h/%h exp 0/0", IF_PC, IF_Instruction); end
        n_tests++; if (dbg_st !== S_FETCH || imem_addr !== 32'h0) begin n_fail++; $display("FAIL rm_state got %0d/%h exp 0/0", dbg_st, imem_addr); end
        @(negedge clk);
        Redirect = 1'b0; reset = 1'b0;
        drive(0, 0, 0, 1, 32'h6666_0000);
        n_tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin n_fail++; $display("FAIL rm_first got %b/%h exp 1/0", imem_req, imem_addr); end
        n_tests++; if (IF_PC !== 32'h4 || IF_Instruction !== 32'h6666_0000) begin n_fail++; $display("FAIL rm_firstout got %h/%h exp 4/66660000", IF_PC, IF_Instruction); end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_redirect_discard();
        test_hold();
        test_redirect_hold();
        test_wrap();
        test_reset_mid_discard();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
